// File: rtl/mac_pe_if.sv
// Bus bundle for one MAC processing element: operand/control inputs, accumulator and
// forwarding outputs. The array driver uses master, the PE uses slave.
interface mac_pe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24
) ();
  logic              en;
  logic              clr;
  logic [DATA_W-1:0] ain;
  logic [DATA_W-1:0] bin;
  logic [ACC_W-1:0]  cout;
  logic              cout_vld;
  logic              ovf;
  logic [DATA_W-1:0] bout;
  logic              en_out;

  modport master (
    output en, clr, ain, bin,
    input  cout, cout_vld, ovf, bout, en_out
  );

  modport slave (
    input  en, clr, ain, bin,
    output cout, cout_vld, ovf, bout, en_out
  );
endinterface

// File: rtl/mac_pe.sv
// Two-stage multiply-accumulate processing element for the systolic array.
// Stage 1 registers the product, stage 2 adds it into the accumulator with optional
// saturation and a sticky overflow flag. Bin/En are forwarded with a one-cycle skew.
module mac_pe #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned SATURATE = 0
) (
  input logic     clk,
  input logic     rst_n,
  mac_pe_if.slave bus
);

  localparam int unsigned ProdW = 2 * DATA_W;

  if (ACC_W < 2 * DATA_W) begin : g_param_err
    $error("mac_pe: ACC_W must be at least 2*DATA_W");
  end

  logic [ProdW-1:0]  a_ext, b_ext, prod_d, prod_q;
  logic              pv_q;
  logic [ACC_W-1:0]  prod_ext, acc_sat, cout_d, cout_q;
  logic [ACC_W:0]    sum_w;
  logic              ovf_hit, ovf_d, ovf_q, vld_q;
  logic [DATA_W-1:0] bout_q;
  logic              en_out_q;

  // Operand extension and product; the low ProdW bits of the extended product are the
  // exact signed or unsigned DATA_W x DATA_W result.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = ProdW'($signed(bus.ain));
      b_ext = ProdW'($signed(bus.bin));
    end else begin
      a_ext = ProdW'(bus.ain);
      b_ext = ProdW'(bus.bin);
    end
    prod_d = a_ext * b_ext;
  end

  // Accumulate with overflow detection; saturation compares against the clamped value.
  always_comb begin
    if (SIGNED != 0) begin
      prod_ext = ACC_W'($signed(prod_q));
    end else begin
      prod_ext = ACC_W'(prod_q);
    end
    sum_w = {1'b0, cout_q} + {1'b0, prod_ext};
    if (SIGNED != 0) begin
      ovf_hit = (cout_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum_w[ACC_W-1] != cout_q[ACC_W-1]);
      // Both operands share a sign on overflow, so the accumulator sign picks the rail.
      acc_sat = cout_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_hit = sum_w[ACC_W];
      acc_sat = '1;
    end
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (pv_q) begin
      cout_d = (ovf_hit && (SATURATE != 0)) ? acc_sat : sum_w[ACC_W-1:0];
      ovf_d  = ovf_q | ovf_hit;
    end
  end

  // Stage 1 product register and neighbour forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      pv_q     <= 1'b0;
      bout_q   <= '0;
      en_out_q <= 1'b0;
    end else if (bus.clr) begin
      prod_q   <= '0;
      pv_q     <= 1'b0;
      bout_q   <= '0;
      en_out_q <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      pv_q     <= bus.en;
      en_out_q <= bus.en;
      if (bus.en) begin
        bout_q <= bus.bin;
      end
    end
  end

  // Stage 2 accumulator, update strobe and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.clr) begin
      cout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cout_q <= cout_d;
      vld_q  <= pv_q;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.cout     = cout_q;
  assign bus.cout_vld = vld_q;
  assign bus.ovf      = ovf_q;
  assign bus.bout     = bout_q;
  assign bus.en_out   = en_out_q;

endmodule

// File: tb/tb_mac_pe.sv
// Scoreboard bench for mac_pe: five configurations share one stimulus stream and are
// checked against an arithmetic reference model of the accumulator.
module tb_mac_pe;

  localparam int NI = 5;
  localparam int unsigned ACCW [NI] = '{24, 16, 16, 16, 16};
  localparam int unsigned SGN  [NI] = '{0, 0, 0, 1, 1};
  localparam int unsigned SAT  [NI] = '{0, 0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] ain = '0;
  logic [7:0] bin = '0;

  logic [23:0] dut_cout [NI];
  logic        dut_vld  [NI];
  logic        dut_ovf  [NI];
  logic        dut_eno  [NI];
  logic [7:0]  dut_bout [NI];

  int cyc = 0;
  int nchecks = 0;
  int nerrs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_pe_if #(.DATA_W(8), .ACC_W(ACCW[g])) bus ();
    assign bus.en  = en;
    assign bus.clr = clr;
    assign bus.ain = ain;
    assign bus.bin = bin;
    assign dut_cout[g] = 24'(bus.cout);
    assign dut_vld[g]  = bus.cout_vld;
    assign dut_ovf[g]  = bus.ovf;
    assign dut_eno[g]  = bus.en_out;
    assign dut_bout[g] = bus.bout;
    mac_pe #(
      .DATA_W(8), .ACC_W(ACCW[g]), .SIGNED(SGN[g]), .SATURATE(SAT[g])
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  typedef struct packed {
    int                    edge_n;
    logic [NI-1:0][23:0]   cout;
    logic [NI-1:0]         ovf;
  } acc_exp_t;

  typedef struct packed {
    int         edge_n;
    logic       en_out;
    logic [7:0] bout;
  } fwd_exp_t;

  acc_exp_t   sb[$];
  fwd_exp_t   fq[$];
  longint     acc_m [NI];
  bit         ovf_m [NI];
  logic [7:0] bout_m = '0;

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  function automatic longint mask_of(input int i);
    return (longint'(1) << ACCW[i]) - 1;
  endfunction

  // Plain-integer accumulator rule: add, then clamp or wrap into the representable range.
  function automatic longint next_acc(input int i, input longint acc, input longint prod,
                                      output bit hit);
    longint m, hi, lo, s;
    m  = longint'(1) << ACCW[i];
    hi = (SGN[i] != 0) ? m / 2 - 1 : m - 1;
    lo = (SGN[i] != 0) ? -(m / 2) : 0;
    s  = acc + prod;
    hit = (s > hi) || (s < lo);
    if (!hit) return s;
    if (SAT[i] != 0) return (s > hi) ? hi : lo;
    s = ((s % m) + m) % m;
    if (s > hi) s -= m;
    return s;
  endfunction

  task automatic model_reset();
    sb.delete();
    fq.delete();
    for (int i = 0; i < NI; i++) begin
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
    end
    bout_m = '0;
  endtask

  // Drive one cycle of inputs and record what the DUTs must show.
  task automatic step(input bit e, input bit c, input logic [7:0] a, input logic [7:0] b);
    int       cap;
    acc_exp_t x;
    longint   pa, pb;
    bit       hit;
    @(posedge clk);
    #2;
    en = e; clr = c; ain = a; bin = b;
    cap = cyc + 1;
    if (c) bout_m = '0;
    else if (e) bout_m = b;
    fq.push_back('{edge_n: cap, en_out: (e && !c), bout: bout_m});
    if (c) begin
      while (sb.size() > 0 && sb[$].edge_n >= cap) void'(sb.pop_back());
      for (int i = 0; i < NI; i++) begin
        acc_m[i] = 0;
        ovf_m[i] = 1'b0;
      end
    end else if (e) begin
      x = '0;
      x.edge_n = cap + 1;
      for (int i = 0; i < NI; i++) begin
        if (SGN[i] != 0) begin
          pa = longint'($signed(a));
          pb = longint'($signed(b));
        end else begin
          pa = longint'(a);
          pb = longint'(b);
        end
        acc_m[i] = next_acc(i, acc_m[i], pa * pb, hit);
        ovf_m[i] = ovf_m[i] | hit;
        x.cout[i] = 24'(acc_m[i] & mask_of(i));
        x.ovf[i]  = ovf_m[i];
      end
      sb.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      chk({name, "_cout"}, i, longint'(dut_cout[i]), 0);
      chk({name, "_vld"},  i, longint'(dut_vld[i]), 0);
      chk({name, "_ovf"},  i, longint'(dut_ovf[i]), 0);
      chk({name, "_eno"},  i, longint'(dut_eno[i]), 0);
      chk({name, "_bout"}, i, longint'(dut_bout[i]), 0);
    end
  endtask

  // Monitor: compare every strobe and forwarding slot against the queued expectations.
  initial begin
    acc_exp_t ea;
    fwd_exp_t ef;
    bit       exp_v;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb.size() > 0 && sb[0].edge_n < cyc) begin
          chk("sb_lost", 0, longint'(sb[0].edge_n), longint'(cyc));
          void'(sb.pop_front());
        end
        exp_v = (sb.size() > 0) && (sb[0].edge_n == cyc);
        for (int i = 0; i < NI; i++) chk("cout_vld", i, longint'(dut_vld[i]), longint'(exp_v));
        if (exp_v) begin
          ea = sb.pop_front();
          for (int i = 0; i < NI; i++) begin
            chk("cout", i, longint'(dut_cout[i]), longint'(ea.cout[i]));
            chk("ovf",  i, longint'(dut_ovf[i]),  longint'(ea.ovf[i]));
          end
        end
        if (fq.size() > 0 && fq[0].edge_n == cyc) begin
          ef = fq.pop_front();
          for (int i = 0; i < NI; i++) begin
            chk("en_out", i, longint'(dut_eno[i]),  longint'(ef.en_out));
            chk("bout",   i, longint'(dut_bout[i]), longint'(ef.bout));
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic accumulate sequence.
    step(1'b1, 1'b0, 8'd3, 8'd5);
    step(1'b1, 1'b0, 8'd2, 8'd7);
    step(1'b1, 1'b0, 8'd255, 8'd255);
    step(1'b1, 1'b0, 8'd1, 8'd1);
    idle(2);
    @(negedge clk);
    chk("tp1_cout", 0, longint'(dut_cout[0]), 65055);
    chk("tp1_ovf",  0, longint'(dut_ovf[0]), 0);

    // Forwarding with an En gap.
    step(1'b1, 1'b0, 8'd0, 8'h11);
    step(1'b0, 1'b0, 8'd0, 8'h22);
    step(1'b1, 1'b0, 8'd0, 8'h33);
    idle(2);

    // Clr together with En, then Clr behind an in-flight product.
    step(1'b0, 1'b1, 8'd0, 8'd0);
    step(1'b1, 1'b0, 8'd10, 8'd10);
    idle(2);
    @(negedge clk);
    chk("clr_pre", 0, longint'(dut_cout[0]), 100);
    step(1'b1, 1'b1, 8'd9, 8'd9);
    idle(1);
    @(negedge clk);
    chk("clr_cout", 0, longint'(dut_cout[0]), 0);
    chk("clr_ovf",  0, longint'(dut_ovf[0]), 0);
    chk("clr_eno",  0, longint'(dut_eno[0]), 0);
    step(1'b1, 1'b0, 8'd5, 8'd5);
    step(1'b0, 1'b1, 8'd0, 8'd0);
    idle(2);
    @(negedge clk);
    chk("clr_drop", 0, longint'(dut_cout[0]), 0);

    // Unsigned 16-bit wrap versus saturate.
    step(1'b0, 1'b1, 8'd0, 8'd0);
    repeat (3) step(1'b1, 1'b0, 8'd255, 8'd255);
    idle(2);
    @(negedge clk);
    chk("uwrap_cout", 1, longint'(dut_cout[1]), 64003);
    chk("uwrap_ovf",  1, longint'(dut_ovf[1]), 1);
    chk("usat_cout",  2, longint'(dut_cout[2]), 65535);
    chk("usat_ovf",   2, longint'(dut_ovf[2]), 1);
    step(1'b1, 1'b0, 8'd255, 8'd255);
    idle(2);
    @(negedge clk);
    chk("usat_hold", 2, longint'(dut_cout[2]), 65535);

    // Signed 16-bit: drive to negative overflow, then back off by one.
    step(1'b0, 1'b1, 8'd0, 8'd0);
    repeat (3) step(1'b1, 1'b0, 8'h80, 8'h7F);
    idle(2);
    @(negedge clk);
    chk("ssat_cout",  4, longint'(dut_cout[4]), 32'h8000);
    chk("ssat_ovf",   4, longint'(dut_ovf[4]), 1);
    chk("swrap_cout", 3, longint'(dut_cout[3]), 16768);
    step(1'b1, 1'b0, 8'hFF, 8'hFF);
    idle(2);
    @(negedge clk);
    chk("ssat_up",  4, longint'(dut_cout[4]), 32'h8001);
    chk("ssat_ovf", 4, longint'(dut_ovf[4]), 1);

    // Asynchronous reset in the middle of a stream.
    step(1'b0, 1'b1, 8'd0, 8'd0);
    repeat (3) step(1'b1, 1'b0, 8'd7, 8'd7);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 8'd4, 8'd4);
    idle(2);
    @(negedge clk);
    chk("rst_first", 0, longint'(dut_cout[0]), 16);

    // Randomised traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(9) < 7), ($urandom_range(24) == 0),
           8'($urandom), 8'($urandom));
    end
    idle(4);
    @(negedge clk);
    chk("sb_drain", 0, longint'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
